micro_sequencer: RTL

Microprogram sequencer for the picoRISC control unit: holds the micro-program counter (mPC) that addresses the control store and computes the next mPC every cycle from the branch field of the current microinstruction. It sits directly downstream of the opcode-to-micro-address mapping stage. In a dispatch microinstruction it loads that stage's 8-bit entry address (20..45, or 0 for no recognised opcode). It also provides conditional micro-branches, wait-on-condition, and a small micro-subroutine stack.

---
 rtl/micro_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the micro-program counter and a small return stack.
// The next mPC is chosen from the branch field of the microinstruction at the current mPC.
module micro_sequencer #(
    parameter int unsigned    AW           = 8,
    parameter int unsigned    NCOND        = 16,
    parameter int unsigned    SDEPTH       = 2,
    parameter logic [AW-1:0]  ILLEGAL_ADDR = {AW{1'b1}}
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             stall_i,
    input  logic [AW-1:0]                    opr_addr_i,
    input  logic [2:0]                       br_type_i,
    input  logic [$clog2(NCOND)-1:0]         cond_sel_i,
    input  logic [NCOND-1:0]                 cond_i,
    input  logic [AW-1:0]                    target_i,
    output logic [AW-1:0]                    mpc_o,
    output logic                             illegal_o,
    output logic                             stk_ovf_o,
    output logic                             stk_unf_o
);

    localparam int unsigned CNTW = $clog2(SDEPTH + 1);

    localparam logic [2:0] BR_NEXT = 3'b000;
    localparam logic [2:0] BR_JMP  = 3'b001;
    localparam logic [2:0] BR_BRC  = 3'b010;
    localparam logic [2:0] BR_DISP = 3'b011;
    localparam logic [2:0] BR_WAIT = 3'b100;
    localparam logic [2:0] BR_END  = 3'b101;
    localparam logic [2:0] BR_CALL = 3'b110;
    localparam logic [2:0] BR_RET  = 3'b111;

    logic [AW-1:0]   mpc_q, mpc_d;
    logic [AW-1:0]   stk_q [SDEPTH];
    logic [AW-1:0]   stk_d [SDEPTH];
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            stk_ovf_q, stk_ovf_d;
    logic            stk_unf_q, stk_unf_d;

    logic            c;
    logic [AW-1:0]   inc;
    logic            push, pop, clr;
    logic            full;

    // Next-mPC selection and stack operation decode
    always_comb begin
        c         = cond_i[cond_sel_i];
        inc       = mpc_q + AW'(1);
        full      = (cnt_q == CNTW'(SDEPTH));
        mpc_d     = inc;
        push      = 1'b0;
        pop       = 1'b0;
        clr       = 1'b0;
        illegal_d = 1'b0;
        stk_ovf_d = 1'b0;
        stk_unf_d = 1'b0;
        case (br_type_i)
            BR_NEXT: mpc_d = inc;
            BR_JMP:  mpc_d = target_i;
            BR_BRC:  mpc_d = c ? target_i : inc;
            BR_DISP: begin
                if (opr_addr_i != '0) begin
                    mpc_d = opr_addr_i;
                end else begin
                    mpc_d     = ILLEGAL_ADDR;
                    illegal_d = 1'b1;
                end
            end
            BR_WAIT: mpc_d = c ? inc : mpc_q;
            BR_END: begin
                mpc_d = '0;
                clr   = 1'b1;
            end
            BR_CALL: begin
                mpc_d     = target_i;
                push      = 1'b1;
                stk_ovf_d = full;
            end
            BR_RET: begin
                if (cnt_q == '0) begin
                    mpc_d     = '0;
                    stk_unf_d = 1'b1;
                end else begin
                    mpc_d = stk_q[0];
                    pop   = 1'b1;
                end
            end
            default: mpc_d = inc;
        endcase
    end

    // Stack is a shift register with the top at index 0; a push when full drops the oldest entry
    always_comb begin
        stk_d = stk_q;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (push) begin
            for (int i = int'(SDEPTH) - 1; i > 0; i--) begin
                stk_d[i] = stk_q[i-1];
            end
            stk_d[0] = inc;
            if (!full) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end else if (pop) begin
            for (int i = 0; i < int'(SDEPTH) - 1; i++) begin
                stk_d[i] = stk_q[i+1];
            end
            stk_d[SDEPTH-1] = '0;
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mpc_q     <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            stk_ovf_q <= 1'b0;
            stk_unf_q <= 1'b0;
            for (int i = 0; i < int'(SDEPTH); i++) begin
                stk_q[i] <= '0;
            end
        end else if (stall_i) begin
            illegal_q <= 1'b0;
            stk_ovf_q <= 1'b0;
            stk_unf_q <= 1'b0;
        end else begin
            mpc_q     <= mpc_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            stk_ovf_q <= stk_ovf_d;
            stk_unf_q <= stk_unf_d;
            stk_q     <= stk_d;
        end
    end

    assign mpc_o     = mpc_q;
    assign illegal_o = illegal_q;
    assign stk_ovf_o = stk_ovf_q;
    assign stk_unf_o = stk_unf_q;

endmodule
